microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 140 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Control-store address sequencer for a microcoded datapath. Each cycle the
// ROM returns the microword at the registered control-store address (CSA).
// The sequencer decodes the word's branch condition and memory-access bits
// and chooses the next CSA. Words that touch memory stall the sequencer
// until main memory signals completion.
//
// Microword fields: RD = [19], WR = [18], COND = [13:11], JADDR = [10:0].
//
// Ports
//   SEQ_CLOCK_50      in   clock, rising edge active
//   SEQ_RESET_InHigh  in   synchronous active-high reset
//   SEQ_Enable_In     in   1 = may advance, 0 = freeze all state
//   SEQ_ROMWord_In    in   [SEQ_WORD_W] microword at SEQ_ROMAddr_Out
//   SEQ_IR_In         in   [32] instruction register
//   SEQ_Flags_In      in   [4] PSR flags {n,z,v,c}
//   SEQ_MemAck_In     in   memory completion strobe
//   SEQ_ROMAddr_Out   out  [SEQ_ADDR_W] registered CSA
//   SEQ_MemReq_Out    out  memory access pending for current word
//   SEQ_Wait_Out      out  1 while the FSM is in WAIT_MEM (FSM state view)
//
// Memory handshake: SEQ_MemReq_Out acts as "valid" for the current word's
// access and is held as long as that word is presented; SEQ_MemAck_In acts as
// "ready" and completes the access in any enabled cycle where both are high.
// The word is not retired (CSA does not advance) until that cycle. An ack with
// no request pending, or while Enable=0, is ignored.
// -----------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int SEQ_ADDR_W = 11,
  parameter int SEQ_WORD_W = 41
) (
  input  logic                  SEQ_CLOCK_50,
  input  logic                  SEQ_RESET_InHigh,
  input  logic                  SEQ_Enable_In,
  input  logic [SEQ_WORD_W-1:0] SEQ_ROMWord_In,
  input  logic [31:0]           SEQ_IR_In,
  input  logic [3:0]            SEQ_Flags_In,
  input  logic                  SEQ_MemAck_In,
  output logic [SEQ_ADDR_W-1:0] SEQ_ROMAddr_Out,
  output logic                  SEQ_MemReq_Out,
  output logic                  SEQ_Wait_Out
);

  typedef enum logic {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } seq_state_t;

  seq_state_t state, state_next;

  logic [SEQ_ADDR_W-1:0] csa, csa_next, csa_inc, jaddr, decode_addr, next_addr;
  logic [2:0]            cond;
  logic                  mem_access;
  logic                  take_jump;

  // Field decode
  assign mem_access = SEQ_ROMWord_In[19] | SEQ_ROMWord_In[18];
  assign cond       = SEQ_ROMWord_In[13:11];
  assign jaddr      = SEQ_ADDR_W'(SEQ_ROMWord_In[10:0]);

  // Dispatch target: opcode bits pick a 4-word slot in the upper half of
  // the control store.
  assign decode_addr = SEQ_ADDR_W'({1'b1, SEQ_IR_In[31:30], SEQ_IR_In[24:19], 2'b00});

  // Natural wrap of the fixed-width adder gives modulo 2^SEQ_ADDR_W.
  assign csa_inc = csa + SEQ_ADDR_W'(1);

  // Flags are used straight from the port so a branch sees the values of
  // the cycle in which it actually retires (including the ack cycle).
  always_comb begin
    take_jump = 1'b0;
    case (cond)
      3'd1:    take_jump = SEQ_Flags_In[3];
      3'd2:    take_jump = SEQ_Flags_In[2];
      3'd3:    take_jump = SEQ_Flags_In[1];
      3'd4:    take_jump = SEQ_Flags_In[0];
      3'd5:    take_jump = SEQ_IR_In[13];
      3'd6:    take_jump = 1'b1;
      default: take_jump = 1'b0;
    endcase
  end

  always_comb begin
    next_addr = csa_inc;
    if (cond == 3'd7) begin
      next_addr = decode_addr;
    end else if (take_jump) begin
      next_addr = jaddr;
    end
  end

  // Next-state / next-CSA
  always_comb begin
    state_next = state;
    csa_next   = csa;
    if (SEQ_Enable_In) begin
      case (state)
        RUN: begin
          // Ack in the same cycle as the request completes it without
          // ever entering WAIT_MEM.
          if (!mem_access || SEQ_MemAck_In) begin
            csa_next = next_addr;
          end else begin
            state_next = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (SEQ_MemAck_In) begin
            csa_next   = next_addr;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge SEQ_CLOCK_50) begin
    if (SEQ_RESET_InHigh) begin
      state <= RUN;
      csa   <= '0;
    end else begin
      state <= state_next;
      csa   <= csa_next;
    end
  end

  assign SEQ_ROMAddr_Out = csa;
  assign SEQ_Wait_Out    = (state == WAIT_MEM);
  // Reset gates the request so memory never sees an access on a reset edge.
  assign SEQ_MemReq_Out  = mem_access & SEQ_Enable_In & ~SEQ_RESET_InHigh;

  // Microword and IR bits that carry datapath controls, not sequencing.
  logic unused_bits;
  assign unused_bits = ^{SEQ_ROMWord_In[SEQ_WORD_W-1:20], SEQ_ROMWord_In[17:14],
                         SEQ_IR_In[29:25], SEQ_IR_In[18:14], SEQ_IR_In[12:0]};

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Directed sequence followed by a randomized run. A reference model tracks
// the expected control-store address and wait status using plain integer
// arithmetic; expected addresses go through exp_q and are popped at the
// check after each clock edge.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

  localparam int AW = 11;
  localparam int WW = 41;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [WW-1:0] word;
  logic [31:0]   ir;
  logic [3:0]    flags;
  logic          ack;
  logic [AW-1:0] rom_addr;
  logic          mem_req;
  logic          wait_o;

  always #5 clk = ~clk;

  microcode_sequencer #(.SEQ_ADDR_W(AW), .SEQ_WORD_W(WW)) dut (
    .SEQ_CLOCK_50     (clk),
    .SEQ_RESET_InHigh (rst),
    .SEQ_Enable_In    (en),
    .SEQ_ROMWord_In   (word),
    .SEQ_IR_In        (ir),
    .SEQ_Flags_In     (flags),
    .SEQ_MemAck_In    (ack),
    .SEQ_ROMAddr_Out  (rom_addr),
    .SEQ_MemReq_Out   (mem_req),
    .SEQ_Wait_Out     (wait_o)
  );

  // ---------------- scoreboard ----------------
  int            tests_run = 0;
  int            failed    = 0;
  logic [AW-1:0] exp_q[$];
  int            m_csa  = 0;
  bit            m_wait = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Where the sequencer goes when the current word retires.
  function automatic int ref_target(input int csa, input logic [WW-1:0] w,
                                    input logic [31:0] r, input logic [3:0] f);
    int  c;
    int  j;
    bit  taken;
    c = int'(w[13:11]);
    j = int'(w[10:0]);
    if (c == 7) return 1024 + int'(r[31:30]) * 256 + int'(r[24:19]) * 4;
    case (c)
      1:       taken = f[3];
      2:       taken = f[2];
      3:       taken = f[1];
      4:       taken = f[0];
      5:       taken = r[13];
      6:       taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken ? j : (csa + 1) % 2048;
  endfunction

  function automatic logic [WW-1:0] mk_word(input bit rd, input bit wr, input int c, input int j);
    logic [WW-1:0] w;
    w[WW-1:20] = 21'($urandom);
    w[19]      = rd;
    w[18]      = wr;
    w[17:14]   = 4'($urandom);
    w[13:11]   = 3'(c);
    w[10:0]    = 11'(j);
    return w;
  endfunction

  // ---------------- driver ----------------
  // One clock: drive inputs, check the combinational request, update the
  // model, clock, then check the registered address and wait status.
  task automatic do_cycle(input bit r, input bit e, input logic [WW-1:0] w,
                          input logic [31:0] i, input logic [3:0] f, input bit a,
                          input string tag);
    bit retire;
    int tgt;
    rst = r; en = e; word = w; ir = i; flags = f; ack = a;
    #1;
    check({tag, "/memreq"}, 32'(mem_req), 32'(!r && e && (w[19] | w[18])));
    tgt    = ref_target(m_csa, w, i, f);
    // A word retires on an ack, or immediately if it needs no memory and
    // no access is outstanding.
    retire = a || (!m_wait && !(w[19] | w[18]));
    if (r) begin
      m_csa = 0; m_wait = 1'b0;
    end else if (e) begin
      if (retire) begin
        m_csa = tgt; m_wait = 1'b0;
      end else begin
        m_wait = 1'b1;
      end
    end
    exp_q.push_back(AW'(m_csa));
    @(posedge clk);
    #1;
    check({tag, "/csa"},  32'(rom_addr), 32'(exp_q.pop_front()));
    check({tag, "/wait"}, 32'(wait_o),   32'(m_wait));
  endtask

  task automatic goto_addr(input int addr);
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 6, addr), $urandom, 4'($urandom), 1'b0, "goto");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  f_on;
    logic [3:0]  f_off;
    logic [31:0] ir_on;
    logic [31:0] ir_off;
    rst = 1'b1; en = 1'b0; word = '0; ir = '0; flags = '0; ack = 1'b0;

    // Reset held two edges, then release with a sequential word at 0.
    do_cycle(1'b1, 1'b1, mk_word(1'b0, 1'b0, 0, 0), 32'h0, 4'h0, 1'b0, "reset0");
    do_cycle(1'b1, 1'b1, mk_word(1'b0, 1'b0, 0, 0), 32'h0, 4'h0, 1'b0, "reset1");
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 0, 0), 32'h0, 4'h0, 1'b0, "first_inc");

    // Decode dispatch from CSA=1
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 7, 5), 32'hC000_0000, 4'h0, 1'b0, "decode_c0");
    goto_addr(1);
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 7, 5), 32'h0080_0000, 4'h0, 1'b0, "decode_0080");

    // Conditional branches, taken and not taken, at CSA=2 -> 12 / 3.
    // The not-taken case sets every other condition source high.
    for (int c = 1; c <= 5; c++) begin
      f_on   = (c <= 4) ? 4'(1 << (4 - c)) : 4'h0;
      f_off  = (c <= 4) ? ~f_on : 4'hF;
      ir_on  = (c == 5) ? 32'h0000_2000 : ($urandom & ~32'h0000_2000);
      ir_off = (c == 5) ? ~32'h0000_2000 : $urandom;
      goto_addr(2);
      do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, c, 12), ir_on,  f_on,  1'b0, "br_taken");
      goto_addr(2);
      do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, c, 12), ir_off, f_off, 1'b0, "br_not_taken");
    end

    // Read stall at 1792: three cycles without ack, then ack.
    goto_addr(1792);
    for (int k = 0; k < 3; k++)
      do_cycle(1'b0, 1'b1, mk_word(1'b1, 1'b0, 0, 0), $urandom, 4'h0, 1'b0, "rd_stall");
    do_cycle(1'b0, 1'b1, mk_word(1'b1, 1'b0, 0, 0), $urandom, 4'h0, 1'b1, "rd_ack");

    // Address wrap
    goto_addr(2047);
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 0, 0), $urandom, 4'h0, 1'b0, "wrap");

    // Enable low in RUN: jump word with ack pending is frozen.
    goto_addr(300);
    for (int k = 0; k < 2; k++)
      do_cycle(1'b0, 1'b0, mk_word(1'b1, 1'b0, 6, 77), $urandom, 4'hF, 1'b1, "hold_run");

    // Enable low in WAIT_MEM: ack ignored until enabled.
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b1, 6, 77), $urandom, 4'h0, 1'b0, "wr_stall");
    for (int k = 0; k < 2; k++)
      do_cycle(1'b0, 1'b0, mk_word(1'b0, 1'b1, 6, 77), $urandom, 4'h0, 1'b1, "hold_wait");
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b1, 6, 77), $urandom, 4'h0, 1'b1, "wr_ack");

    // Stray ack with no access in RUN
    do_cycle(1'b0, 1'b1, mk_word(1'b0, 1'b0, 0, 9), $urandom, 4'h0, 1'b1, "stray_ack");

    // Ack sampled in the ack cycle: flags change between stall and ack.
    goto_addr(40);
    do_cycle(1'b0, 1'b1, mk_word(1'b1, 1'b0, 2, 500), $urandom, 4'b0100, 1'b0, "late_flag_stall");
    do_cycle(1'b0, 1'b1, mk_word(1'b1, 1'b0, 2, 500), $urandom, 4'b0000, 1'b1, "late_flag_ack");

    // Reset during WAIT_MEM with ack on the same edge
    goto_addr(5);
    do_cycle(1'b0, 1'b1, mk_word(1'b1, 1'b0, 6, 100), $urandom, 4'h0, 1'b0, "pre_rst_stall");
    do_cycle(1'b1, 1'b1, mk_word(1'b1, 1'b0, 6, 100), $urandom, 4'h0, 1'b1, "rst_in_wait");

    // Randomized run
    for (int n = 0; n < 500; n++) begin
      do_cycle($urandom_range(0, 39) == 0,
               $urandom_range(0, 7) != 0,
               mk_word($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 7), $urandom_range(0, 2047)),
               $urandom, 4'($urandom), $urandom_range(0, 2) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
